// File: rtl/adc_readout_ctrl.sv
// rtl/adc_readout_ctrl.sv - ADC acquisition sequencer: arms capture, tracks ping-pong banks, streams bank bytes.
// Defining ADC_READOUT_HEADER_EN prefixes every frame with 0xA5 and a status byte.
module adc_readout_ctrl #(
  parameter int FRAME_BYTES = 256,
  parameter int ADDR_W      = 8,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              res,
  input  logic              arm,
  input  logic              stop,
  input  logic              continuous,
  input  logic [2:0]        rate_in,
  output logic [2:0]        rate,
  output logic              start_pulse,
  input  logic              write_done,
  output logic              read_bank,
  output logic [ADDR_W-1:0] read_addr,
  input  logic [7:0]        dout,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              overrun,
  output logic [CNT_W-1:0]  frame_cnt
);

  typedef enum logic [3:0] {
    IDLE,
    START,
    WAIT_FILL,
    RD_ADDR,
    RD_CAP,
    SEND,
    NEXT
`ifdef ADC_READOUT_HEADER_EN
    ,
    HDR0,
    HDR1
`endif
  } state_t;

`ifdef ADC_READOUT_HEADER_EN
  localparam state_t FIRST_RD = HDR0;
`else
  localparam state_t FIRST_RD = RD_ADDR;
`endif

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_BYTES - 1);

  state_t            state, state_nxt;
  logic [2:0]        rate_nxt;
  logic              read_bank_nxt;
  logic [ADDR_W-1:0] read_addr_nxt;
  logic [7:0]        tx_data_nxt;
  logic              tx_valid_nxt;
  logic              overrun_nxt;
  logic [CNT_W-1:0]  frame_cnt_nxt;
  logic              wr_bank, wr_bank_nxt;
  logic              pending, pending_nxt;
  logic              stop_req, stop_req_nxt;

  assign busy        = (state != IDLE);
  assign start_pulse = (state == START);

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state     <= IDLE;
      rate      <= '0;
      read_bank <= 1'b0;
      read_addr <= '0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_cnt <= '0;
      wr_bank   <= 1'b0;
      pending   <= 1'b0;
      stop_req  <= 1'b0;
    end else begin
      state     <= state_nxt;
      rate      <= rate_nxt;
      read_bank <= read_bank_nxt;
      read_addr <= read_addr_nxt;
      tx_data   <= tx_data_nxt;
      tx_valid  <= tx_valid_nxt;
      overrun   <= overrun_nxt;
      frame_cnt <= frame_cnt_nxt;
      wr_bank   <= wr_bank_nxt;
      pending   <= pending_nxt;
      stop_req  <= stop_req_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    rate_nxt      = rate;
    read_bank_nxt = read_bank;
    read_addr_nxt = read_addr;
    tx_data_nxt   = tx_data;
    tx_valid_nxt  = tx_valid;
    overrun_nxt   = overrun;
    frame_cnt_nxt = frame_cnt;
    wr_bank_nxt   = wr_bank;
    pending_nxt   = pending;
    stop_req_nxt  = stop_req;

    // A bank completing while we are still reading: queue one, drop later ones (keep oldest).
    if (write_done && state != IDLE && state != WAIT_FILL && state != NEXT) begin
      if (!pending) begin
        pending_nxt = 1'b1;
        wr_bank_nxt = ~wr_bank;
      end else begin
        overrun_nxt = 1'b1;
      end
    end

    if (stop && state != IDLE && state != WAIT_FILL)
      stop_req_nxt = 1'b1;

    case (state)
      IDLE: begin
        stop_req_nxt = 1'b0;
        if (arm) begin
          rate_nxt      = rate_in;
          overrun_nxt   = 1'b0;
          frame_cnt_nxt = '0;
          pending_nxt   = 1'b0;
          wr_bank_nxt   = 1'b0;
          state_nxt     = START;
        end
      end

      START: state_nxt = WAIT_FILL;

      WAIT_FILL: begin
        if (stop || stop_req) begin
          state_nxt = IDLE;
        end else if (write_done) begin
          read_bank_nxt = wr_bank;
          wr_bank_nxt   = ~wr_bank;
          read_addr_nxt = '0;
          state_nxt     = FIRST_RD;
        end
      end

      RD_ADDR: state_nxt = RD_CAP;

      RD_CAP: begin
        tx_data_nxt  = dout;
        tx_valid_nxt = 1'b1;
        state_nxt    = SEND;
      end

      SEND: begin
        if (tx_ready) begin
          tx_valid_nxt = 1'b0;
          if (read_addr == LAST_ADDR) begin
            frame_cnt_nxt = frame_cnt + CNT_W'(1);
            state_nxt     = NEXT;
          end else begin
            read_addr_nxt = read_addr + ADDR_W'(1);
            state_nxt     = RD_ADDR;
          end
        end
      end

      NEXT: begin
        if (stop || stop_req || !continuous) begin
          state_nxt = IDLE;
        end else if (pending) begin
          // The queued bank is the one not just read; a fresh bank-full re-queues.
          read_bank_nxt = ~read_bank;
          read_addr_nxt = '0;
          pending_nxt   = write_done;
          if (write_done)
            wr_bank_nxt = ~wr_bank;
          state_nxt = FIRST_RD;
        end else if (write_done) begin
          read_bank_nxt = wr_bank;
          wr_bank_nxt   = ~wr_bank;
          read_addr_nxt = '0;
          state_nxt     = FIRST_RD;
        end else begin
          state_nxt = WAIT_FILL;
        end
      end

`ifdef ADC_READOUT_HEADER_EN
      HDR0: begin
        if (!tx_valid) begin
          tx_data_nxt  = 8'hA5;
          tx_valid_nxt = 1'b1;
        end else if (tx_ready) begin
          tx_valid_nxt = 1'b0;
          state_nxt    = HDR1;
        end
      end

      HDR1: begin
        if (!tx_valid) begin
          tx_data_nxt  = {overrun, read_bank, frame_cnt[5:0]};
          tx_valid_nxt = 1'b1;
        end else if (tx_ready) begin
          tx_valid_nxt = 1'b0;
          state_nxt    = RD_ADDR;
        end
      end
`endif

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_adc_readout_ctrl.sv
// tb/tb_adc_readout_ctrl.sv - directed, table-driven bench for adc_readout_ctrl with a registered ping-pong RAM model.
module tb_adc_readout_ctrl;

  localparam int FB = 256;

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic        arm = 1'b0;
  logic        stop = 1'b0;
  logic        continuous = 1'b0;
  logic [2:0]  rate_in = 3'd0;
  logic [2:0]  rate;
  logic        start_pulse;
  logic        write_done = 1'b0;
  logic        read_bank;
  logic [7:0]  read_addr;
  logic [7:0]  dout;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        busy;
  logic        overrun;
  logic [15:0] frame_cnt;

  logic [7:0]  mem [512];
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_start = 0;

  adc_readout_ctrl dut (
    .clk(clk), .res(res), .arm(arm), .stop(stop), .continuous(continuous),
    .rate_in(rate_in), .rate(rate), .start_pulse(start_pulse), .write_done(write_done),
    .read_bank(read_bank), .read_addr(read_addr), .dout(dout), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .overrun(overrun),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) dout <= mem[{read_bank, read_addr}];

  always @(negedge clk) if (start_pulse) n_start++;

  function automatic logic [7:0] exp_byte(input logic b, input int idx);
    logic [7:0] v;
    v = 8'((idx * 37 + 11) & 255);
    if (b) v = v ^ 8'h5A;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    string      name;
    logic [2:0] rate;
    logic       cont;
    int         wd2_at;
    int         wd3_at;
    int         stall_at;
    int         stall_len;
    int         stop_at;
    int         exp_bytes;
    logic [1:0] exp_banks;
    logic       exp_ovr;
    int         exp_fcnt;
    int         exp_gap;
  } vec_t;

  vec_t vecs [5];

  task automatic do_arm(input logic [2:0] r, input logic c);
    @(negedge clk);
    rate_in = r; continuous = c; arm = 1'b1;
    @(negedge clk);
    arm = 1'b0; rate_in = ~r;
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    int nbytes, data_err, stall_err, stall_seen, first_valid, c255, c256, start0, idx;
    logic wd2_f, wd3_f, stop_f, bank;
    logic [7:0] snap_d, snap_a;
    nbytes = 0; data_err = 0; stall_err = 0; stall_seen = 0; first_valid = -1;
    c255 = 0; c256 = 0; wd2_f = 0; wd3_f = 0; stop_f = 0; snap_d = 0; snap_a = 0;
    start0 = n_start;
    do_arm(v.rate, v.cont);
    check({v.name, "/rate"}, 32'(rate), 32'(v.rate));
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      write_done = (cyc == 0);
      stop = 1'b0;
      if (!wd2_f && v.wd2_at >= 0 && nbytes == v.wd2_at) begin write_done = 1'b1; wd2_f = 1'b1; end
      if (!wd3_f && v.wd3_at >= 0 && nbytes == v.wd3_at) begin write_done = 1'b1; wd3_f = 1'b1; end
      if (!stop_f && v.stop_at >= 0 && nbytes == v.stop_at) begin stop = 1'b1; stop_f = 1'b1; end
      if (cyc > 0 && !busy) break;
      if (tx_valid && first_valid < 0) first_valid = cyc;
      tx_ready = 1'b1;
      if (nbytes == v.stall_at && stall_seen > 0 && stall_seen < v.stall_len && !tx_valid) stall_err++;
      if (tx_valid) begin
        if (nbytes == v.stall_at && stall_seen < v.stall_len) begin
          tx_ready = 1'b0;
          if (stall_seen == 0) begin snap_d = tx_data; snap_a = read_addr; end
          else if (tx_data !== snap_d || read_addr !== snap_a) stall_err++;
          stall_seen++;
        end else begin
          if (nbytes == v.stall_at && stall_seen > 0 && (tx_data !== snap_d || read_addr !== snap_a)) stall_err++;
          bank = (nbytes < FB) ? v.exp_banks[0] : v.exp_banks[1];
          idx  = nbytes % FB;
          if (nbytes >= v.exp_bytes || tx_data !== exp_byte(bank, idx) ||
              read_addr !== 8'(idx) || read_bank !== bank) data_err++;
          if (nbytes == FB - 1) c255 = cyc;
          if (nbytes == FB) c256 = cyc;
          nbytes++;
        end
      end
    end
    write_done = 1'b0; stop = 1'b0; tx_ready = 1'b1;
    check({v.name, "/latency"}, first_valid, 3);
    check({v.name, "/bytes"}, nbytes, v.exp_bytes);
    check({v.name, "/data_errors"}, data_err, 0);
    check({v.name, "/stall_cycles"}, stall_seen, v.stall_len);
    check({v.name, "/stall_errors"}, stall_err, 0);
    check({v.name, "/overrun"}, 32'(overrun), 32'(v.exp_ovr));
    check({v.name, "/frame_cnt"}, 32'(frame_cnt), v.exp_fcnt);
    check({v.name, "/busy_end"}, 32'(busy), 0);
    check({v.name, "/start_pulses"}, n_start - start0, 1);
    if (v.exp_gap > 0) check({v.name, "/bank_gap"}, c256 - c255, v.exp_gap);
    @(negedge clk);
  endtask

  initial begin
    int nb;
    logic got;
    for (int i = 0; i < 512; i++) mem[i] = exp_byte(i >= 256, i % 256);

    vecs[0] = '{"basic",     3'd3, 1'b0, -1, -1, -1,  0,  -1, 256, 2'b00, 1'b0, 1, 0};
    vecs[1] = '{"backpress", 3'd5, 1'b0, -1, -1, 17, 10,  -1, 256, 2'b00, 1'b0, 1, 0};
    vecs[2] = '{"pingpong",  3'd1, 1'b1, 40, -1, -1,  0, 512, 512, 2'b10, 1'b0, 2, 4};
    vecs[3] = '{"stop100",   3'd2, 1'b1, -1, -1, -1,  0, 100, 256, 2'b00, 1'b0, 1, 0};
    vecs[4] = '{"overrun",   3'd6, 1'b1, 40, 80, -1,  0, 512, 512, 2'b10, 1'b1, 2, 4};

    #1 res = 1'b0;
    repeat (2) @(negedge clk);
    check("reset/busy", 32'(busy), 0);
    check("reset/tx_valid", 32'(tx_valid), 0);
    check("reset/start_pulse", 32'(start_pulse), 0);
    check("reset/rate_frame_ovr", {13'd0, rate, frame_cnt}, 32'd0);
    check("reset/addr_bank_data", {15'd0, overrun, read_bank, read_addr, tx_data}, 32'd0);
    res = 1'b1;

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    do_arm(3'd0, 1'b0);
    check("rearm/overrun_clear", 32'(overrun), 0);
    check("rearm/frame_cnt_clear", 32'(frame_cnt), 0);
    check("rearm/busy", 32'(busy), 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("stop_wait_fill/idle", 32'(busy), 0);
    write_done = 1'b1;
    @(negedge clk);
    write_done = 1'b0;
    @(negedge clk);
    check("idle_write_done/busy", 32'(busy), 0);
    check("idle_write_done/tx_valid", 32'(tx_valid), 0);

    do_arm(3'd3, 1'b0);
    write_done = 1'b1;
    @(negedge clk);
    write_done = 1'b0;
    nb = 0; got = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      if (tx_valid) begin
        if (nb == 50) begin got = 1'b1; break; end
        nb++;
      end
      @(negedge clk);
    end
    check("midreset/reached_byte50", 32'(got), 1);
    check("midreset/addr_before", 32'(read_addr), 50);
    tx_ready = 1'b0;
    res = 1'b0;
    #1;
    check("midreset/tx_valid", 32'(tx_valid), 0);
    check("midreset/busy", 32'(busy), 0);
    check("midreset/addr_rate", {21'd0, rate, read_addr}, 32'd0);
    @(negedge clk);
    res = 1'b1; tx_ready = 1'b1;
    do_arm(3'd4, 1'b0);
    write_done = 1'b1;
    @(negedge clk);
    write_done = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (tx_valid) begin got = 1'b1; break; end
      @(negedge clk);
    end
    check("restart/valid_seen", 32'(got), 1);
    check("restart/first_byte", 32'(tx_data), 32'(exp_byte(1'b0, 0)));
    check("restart/addr_bank", {23'd0, read_bank, read_addr}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/adc_readout_ctrl.md
Name: adc_readout_ctrl

Overview:
- Sequencer for the ADC acquisition path (SPI ADC, buffer write control, ping-pong buffer).
- Arms an acquisition, latches the decimation rate and waits for each 256-byte bank-full event.
- Reads the completed bank out of the ping-pong buffer and streams the bytes to the uC/UART side over a valid/ready byte handshake.
- Tracks frames, pending banks and overruns.

Parameters:
- FRAME_BYTES, 256, bytes per bank; power of 2, at most 2^ADDR_W.
- ADDR_W, 8, width of read_addr.
- CNT_W, 16, width of frame_cnt.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- res  input  1  asynchronous, active-low reset.
- arm  input  1  single-cycle command: start acquisition.
- stop  input  1  single-cycle command: stop acquisition.
- continuous  input  1  1 = keep reading successive banks; 0 = one frame then idle.
- rate_in  input  3  requested decimation rate, latched on arm.
- rate  output  3  latched rate, to the ADC decimator.
- start_pulse  output  1  one-cycle pulse to the buffer write controller.
- write_done  input  1  one-cycle pulse: a bank of FRAME_BYTES has been written.
- read_bank  output  1  bank being read (MSB of the 9-bit buffer address).
- read_addr  output  ADDR_W  byte address within the bank.
- dout  input  8  buffer read data; valid 1 clk after read_addr/read_bank change (registered RAM).
- tx_data  output  8  byte to the consumer.
- tx_valid  output  1  tx_data valid.
- tx_ready  input  1  consumer accepts the byte when tx_valid && tx_ready.
- busy  output  1  state != IDLE.
- overrun  output  1  sticky: a bank was lost.
- frame_cnt  output  CNT_W  frames fully transmitted since arm; wraps modulo 2^CNT_W.

Behaviour:
- Reset values: all outputs 0, rate = 0, wr_bank = 0, pending = 0, state IDLE.
- States:
  - IDLE: on arm, latch rate <= rate_in, clear overrun/frame_cnt/pending, wr_bank <= 0, go to START. arm while busy is ignored.
  - START: assert start_pulse for exactly 1 cycle, go to WAIT_FILL.
  - WAIT_FILL: on write_done, read_bank <= wr_bank, wr_bank toggles, read_addr <= 0, go to RD_ADDR. On stop, go to IDLE immediately.
  - RD_ADDR: address presented; 1 wait cycle, go to RD_CAP.
  - RD_CAP: tx_data <= dout, tx_valid <= 1, go to SEND.
  - SEND: hold tx_data/tx_valid stable until tx_ready. On acceptance, tx_valid falls next cycle.
    - Not last byte: read_addr+1, go to RD_ADDR.
    - Last byte (read_addr == FRAME_BYTES-1): frame_cnt+1, go to NEXT.
  - NEXT:
    - stop_req set or continuous = 0: go to IDLE.
    - pending set: clear pending, read the other bank (same setup as WAIT_FILL), go to RD_ADDR.
    - Otherwise: go to WAIT_FILL.
- Throughput: max 1 byte per 3 clks. Latency from the write_done edge to the first tx_valid is 3 clks.
- write_done outside WAIT_FILL (busy): if pending = 0, set pending and toggle wr_bank. If pending = 1, set overrun and leave wr_bank unchanged (oldest data is kept).
- write_done in IDLE is ignored.
- stop outside WAIT_FILL sets stop_req. The current frame completes; stop_req is cleared in IDLE.
- write_done in the same cycle as a last-byte acceptance counts as pending.
- Reset mid-frame: immediate return to reset values; tx_valid drops asynchronously.

Optional Feature:
- Macro: ADC_READOUT_HEADER_EN.
- Defined: each frame is preceded by 2 header bytes through the same handshake: 0xA5, then {overrun, read_bank, frame_cnt[5:0]}. Two extra states HDR0/HDR1 run before the first RD_ADDR.
- Undefined: no header; the states are absent and frames are exactly FRAME_BYTES bytes.

Test Plan:
- Basic frame: arm with rate_in = 3, continuous = 0, tx_ready = 1.
  - Expect rate = 3 and one start_pulse.
  - On write_done, expect 256 bytes from bank 0, addresses 0..255 in order, each equal to the RAM model contents.
  - Expect frame_cnt = 1, then busy = 0.
- Backpressure: tx_ready low for 10 clks on byte 17. Expect tx_data and tx_valid stable, no address advance, no lost or duplicated byte.
- Ping-pong pending: continuous = 1, second write_done at byte 40 of bank 0. Expect bank 1 read immediately after byte 255 with no WAIT_FILL, and overrun = 0.
- Overrun: three write_done pulses during one frame. Expect overrun = 1 sticky and read order bank 0 then bank 1; re-arm clears overrun.
- Stop: stop in WAIT_FILL gives IDLE next clk. Stop at byte 100 still delivers all 256 bytes, then IDLE with frame_cnt incremented.
- Reset: res low at byte 50. Expect all outputs 0 asynchronously; after release, arm restarts from bank 0, address 0.
